neg_arbiter: RTL and testbench
==============================

# neg_arbiter

Round-robin arbiter and sequencer that shares one two's-complement negation unit (result = ~operand + 1) among four requesters in the simple CPU datapath. It captures one requester's operand per grant, computes the negation into a one-entry output register, and presents the result with the winning requester's ID on a valid/ready output port. It is used by the ALU, address-offset, and branch-displacement paths so that only one negation unit exists in the design.

## Interface
- `size`, default 16: operand and result width in bits.
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `req`, input, 4: per-requester request level; `req[i]` is held high until `ack[i]`.
- `operand`, input, 4*size: packed operands; requester i drives `operand[i*size +: size]`, which is stable while `req[i]` is high.
- `ack`, output, 4: one-hot, one-cycle pulse; `ack[i]` means the operand of requester i was captured on this edge.
- `out_valid`, output, 1: the result register holds an unconsumed result.
- `out_ready`, input, 1: the consumer accepts the result when it is high together with `out_valid`.
- `out_data`, output, size: `~operand + 1` of the granted requester, modulo 2^size.
- `out_id`, output, 2: index of the requester that produced `out_data`.
- `out_ovf`, output, 1: the operand was the most negative value (1 followed by size-1 zeros). See Configuration.

## Operation
- There are two states. In EMPTY, `out_valid` is 0. In FULL, `out_valid` is 1.
- The block may capture an operand when it is in EMPTY, or when it is in FULL and `out_valid & out_ready` in the same cycle (pass-through, giving full throughput).
- Grant is decided combinationally from `req` and the 2-bit priority pointer `ptr`. The winner is the first requester with `req` high, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- On a capture edge:
  - Load `out_data` with `~operand[win] + 1`, load `out_id` with `win`, and load `out_ovf`.
  - Pulse `ack[win]` high for exactly that cycle. `ack` is driven combinationally in the cycle the capture edge closes.
  - Set `ptr` to `win + 1` (mod 4). The state becomes or stays FULL.
- If the output is consumed and no `req` is high, the state goes to EMPTY and the output registers hold their last values.
- If the block is in FULL, `out_ready` is low, and a request is pending: no `ack` is given and the request waits. There is no starvation, because round-robin guarantees that each waiting requester is served within 4 captures.
- Arithmetic: wrap-around within `size` bits. 0 maps to 0. The most negative value maps to itself.
- `ack` never pulses for a requester whose `req` is low. At most one `ack` bit is high per cycle.

## Timing
- Reset values:
  - `out_valid` = 0
  - `out_data` = 0
  - `out_id` = 0
  - `out_ovf` = 0
  - `ack` = 0
  - `ptr` = 0
  - state = EMPTY
- Latency: a request that is accepted at edge N has its result visible from the output of edge N (registered), so `out_valid` is high in cycle N+1.
- Throughput: one result per cycle while `out_ready` stays high.
- `ack[i]` is combinational: it is high in the cycle before the capture edge. Requesters sample `ack` at that edge and drop or change `req` afterwards.
- Reset asserted mid-operation immediately clears `out_valid` and `ptr`, and discards any held result. A requester whose request was not acked must keep `req` asserted after reset.
- The outputs remain stable while `out_valid & ~out_ready`.

## Configuration
- `NEG_ARB_OVF_EN`
  - When defined: `out_ovf` is registered with the result. It is 1 when the captured operand equals 1 followed by size-1 zeros (for example, 16'h8000 when size=16).
  - When not defined: `out_ovf` is tied to 0 and no overflow comparator or flop is built. The port is always present.

## Test plan
- Reset, then a single request: `req`=4'b0001, operand0=16'h0005, `out_ready`=1 → `ack`=4'b0001 for one cycle; the next cycle has `out_valid`=1, `out_data`=16'hFFFB, `out_id`=0.
- All four requesting with `out_ready`=1 and operands 1, 2, 3, 4 → acks in the order 0, 1, 2, 3 on consecutive cycles; results are FFFF, FFFE, FFFD, FFFC with IDs 0, 1, 2, 3 back-to-back.
- Backpressure: with FULL and `out_ready`=0 for 5 cycles while `req`=4'b0100 → no `ack` is given and `out_data`/`out_id` are stable; when `out_ready` rises, the same edge captures requester 2.
- Fairness: with `ptr`=3, requesters 0 and 3 hold `req` continuously → grants alternate 3, 0, 3, 0.
- Boundaries: operand 16'h0000 → 16'h0000 with `out_ovf`=0. Operand 16'h8000 → 16'h8000 with `out_ovf`=1 when `NEG_ARB_OVF_EN` is defined, and 0 when it is not.
- Asserting `rst` asynchronously while FULL → `out_valid`=0 before the next edge; after release, the pending `req`=4'b0010 is acked first and `ptr` becomes 2.

Source files
------------

// File: rtl/neg_arbiter.sv
// Round-robin arbiter sharing one two's-complement negation unit among four requesters.
// Optional NEG_ARB_OVF_EN registers a most-negative-operand flag; otherwise out_ovf is tied to 0.
module neg_arbiter #(
  parameter int size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*size-1:0]   operand,
  output logic [3:0]          ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [size-1:0]     out_data,
  output logic [1:0]          out_id,
  output logic                out_ovf,
  output logic                fsm_state,
  output logic [1:0]          ptr
);

  // Handshake: a result transfers on an edge where out_valid & out_ready are both high;
  // req[i] is held until ack[i], and ack[i] marks the edge that captures operand i.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_next;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            any_req;
  logic            capture;
  logic [size-1:0] win_op;

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    win     = ptr;
    any_req = 1'b0;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  assign win_op    = operand[win*size +: size];
  assign capture   = any_req & ((state == EMPTY) | out_ready);
  assign ack       = capture ? (4'b0001 << win) : 4'b0000;
  assign out_valid = (state == FULL);
  assign fsm_state = state;

  always_comb begin
    state_next = state;
    if (capture)
      state_next = FULL;
    else if ((state == FULL) && out_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      ptr      <= 2'd0;
      out_data <= '0;
      out_id   <= 2'd0;
    end else begin
      state <= state_next;
      if (capture) begin
        ptr      <= win + 2'd1;
        out_data <= ~win_op + 1'b1;
        out_id   <= win;
      end
    end
  end

`ifdef NEG_ARB_OVF_EN
  localparam logic [size-1:0] MinNeg = {1'b1, {(size-1){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_ovf <= 1'b0;
    else if (capture)
      out_ovf <= (win_op == MinNeg);
  end
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_neg_arbiter.sv
// Self-checking bench for neg_arbiter: result scoreboard plus per-scenario inline checks.
module tb_neg_arbiter;
  localparam int size = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        req = 4'b0;
  logic [4*size-1:0] operand = '0;
  logic [3:0]        ack;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [size-1:0]   out_data;
  logic [1:0]        out_id;
  logic              out_ovf;
  logic              fsm_state;
  logic [1:0]        ptr;

  int passed = 0;
  int total  = 0;

  // {ovf, id, data}
  logic [size+2:0] exp_q[$];

  neg_arbiter #(.size(size)) dut (
    .clk(clk), .rst(rst), .req(req), .operand(operand), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_ovf(out_ovf), .fsm_state(fsm_state), .ptr(ptr)
  );

  always #5 clk = ~clk;

  function automatic logic [size+2:0] model(input logic [1:0] id, input logic [size-1:0] op);
    logic [size-1:0] neg;
    logic            ovf;
    neg = size'(0 - int'(op));
    ovf = 1'b0;
`ifdef NEG_ARB_OVF_EN
    ovf = (op == 16'h8000);
`endif
    return {ovf, id, neg};
  endfunction

  task automatic set_op(input int i, input logic [size-1:0] v);
    operand[i*size +: size] = v;
  endtask

  // Scoreboard: a result is consumed on the edge after a sample with valid & ready.
  initial begin
    logic [size+2:0] exp_v;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_unexpected: got id=%0d data=%h, no result expected", out_id, out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_ovf, out_id, out_data} !== exp_v)
            $display("FAIL scoreboard_result: got ovf=%0b id=%0d data=%h, want ovf=%0b id=%0d data=%h",
                     out_ovf, out_id, out_data, exp_v[size+2], exp_v[size+1:size], exp_v[size-1:0]);
          else
            passed++;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    req = 4'b0; out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain_timeout: %0d results left, want 0", exp_q.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req = 4'b0; out_ready = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL reset_data: got %h want 0000", out_data); else passed++;
    total++; if (out_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", out_id); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf: got %0b want 0", out_ovf); else passed++;
    total++; if (ack !== 4'b0) $display("FAIL reset_ack: got %b want 0000", ack); else passed++;
    total++; if (ptr !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", ptr); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    req = 4'b0001; set_op(0, 16'h0005); out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0001) $display("FAIL single_ack: got %b want 0001", ack); else passed++;
    exp_q.push_back(model(2'd0, 16'h0005));
    @(negedge clk);
    req = 4'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'hFFFB || out_id !== 2'd0)
      $display("FAIL single_result: got v=%0b data=%h id=%0d want v=1 data=fffb id=0", out_valid, out_data, out_id);
    else passed++;
    drain();
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1));
    req = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (ack !== (4'b0001 << k)) $display("FAIL b2b_ack%0d: got %b want %b", k, ack, 4'b0001 << k);
      else passed++;
      exp_q.push_back(model(2'(k), 16'(k + 1)));
      @(negedge clk);
      req[k] = 1'b0;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [size-1:0] held;
    do_reset();
    @(negedge clk);
    req = 4'b0001; set_op(0, 16'h0007); out_ready = 1'b0;
    #1;
    total++; if (ack !== 4'b0001) $display("FAIL bp_first_ack: got %b want 0001", ack); else passed++;
    exp_q.push_back(model(2'd0, 16'h0007));
    @(negedge clk);
    req = 4'b0100; set_op(2, 16'h0009);
    held = 16'hFFF9;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if (ack !== 4'b0 || out_data !== held || out_id !== 2'd0 || out_valid !== 1'b1)
        $display("FAIL bp_stall%0d: got ack=%b data=%h id=%0d v=%0b want ack=0000 data=%h id=0 v=1",
                 c, ack, out_data, out_id, out_valid, held);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0100) $display("FAIL bp_release_ack: got %b want 0100", ack); else passed++;
    exp_q.push_back(model(2'd2, 16'h0009));
    @(negedge clk);
    req = 4'b0;
    drain();
  endtask

  task automatic test_fairness();
    logic [1:0] want;
    do_reset();
    @(negedge clk);
    req = 4'b0100; set_op(2, 16'h0001); out_ready = 1'b1;
    #1;
    exp_q.push_back(model(2'd2, 16'h0001));
    @(negedge clk);
    req = 4'b1001; set_op(0, 16'h0010); set_op(3, 16'h0030);
    #1;
    total++; if (ptr !== 2'd3) $display("FAIL fair_ptr: got %0d want 3", ptr); else passed++;
    want = 2'd3;
    for (int g = 0; g < 4; g++) begin
      total++;
      if (ack !== (4'b0001 << want)) $display("FAIL fair_grant%0d: got %b want %b", g, ack, 4'b0001 << want);
      else passed++;
      exp_q.push_back(model(want, (want == 2'd3) ? 16'h0030 : 16'h0010));
      want = (want == 2'd3) ? 2'd0 : 2'd3;
      @(negedge clk);
      #1;
    end
    req = 4'b0;
    drain();
  endtask

  task automatic test_boundaries();
    logic want_ovf;
    want_ovf = 1'b0;
`ifdef NEG_ARB_OVF_EN
    want_ovf = 1'b1;
`endif
    do_reset();
    @(negedge clk);
    req = 4'b0001; set_op(0, 16'h0000); out_ready = 1'b1;
    #1;
    exp_q.push_back(model(2'd0, 16'h0000));
    @(negedge clk);
    req = 4'b0010; set_op(1, 16'h8000);
    #1;
    total++;
    if (out_data !== 16'h0000 || out_ovf !== 1'b0)
      $display("FAIL bound_zero: got data=%h ovf=%0b want data=0000 ovf=0", out_data, out_ovf);
    else passed++;
    exp_q.push_back(model(2'd1, 16'h8000));
    @(negedge clk);
    req = 4'b0;
    #1;
    total++;
    if (out_data !== 16'h8000 || out_ovf !== want_ovf || out_id !== 2'd1)
      $display("FAIL bound_minneg: got data=%h ovf=%0b id=%0d want data=8000 ovf=%0b id=1",
               out_data, out_ovf, out_id, want_ovf);
    else passed++;
    drain();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    req = 4'b0001; set_op(0, 16'h0003); out_ready = 1'b0;
    @(negedge clk);
    req = 4'b0010; set_op(1, 16'h0006);
    #1;
    total++;
    if (out_valid !== 1'b1 || ack !== 4'b0)
      $display("FAIL arst_full: got v=%0b ack=%b want v=1 ack=0000", out_valid, ack);
    else passed++;
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || ptr !== 2'd0)
      $display("FAIL arst_clear: got v=%0b ptr=%0d want v=0 ptr=0", out_valid, ptr);
    else passed++;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    total++; if (ack !== 4'b0010) $display("FAIL arst_ack: got %b want 0010", ack); else passed++;
    exp_q.push_back(model(2'd1, 16'h0006));
    @(negedge clk);
    req = 4'b0;
    #1;
    total++; if (ptr !== 2'd2) $display("FAIL arst_ptr: got %0d want 2", ptr); else passed++;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_fairness();
    test_boundaries();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
